// File: rtl/cdc_pkg.sv
// Shared types and helpers for the toggle-handshake CDC transmitter.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Width of a counter that must reach TIMEOUT_CYCLES; kept >=1 so a disabled timeout still elaborates.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_bit_arn.sv
// N-flop single-bit synchronizer, async active-low reset to 0.
module sync_bit_arn #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], i_d};
    end
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side end of a two-phase req/ack handshake: holds a word on o_data and toggles o_req
// until the synchronized ack toggle comes back, with timeout and spurious-ack fault detection.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_req,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ack_async,
  output logic             o_done,
  output logic             o_fault,
  input  logic             i_fault_clr
);

  localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           r_state, w_state_nxt;
  logic             r_req, w_req_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_fault, w_fault_nxt;
  logic             w_ack_s;

  sync_bit_arn #(.N(SYNC_STAGES)) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ack_async),
    .o_q     (w_ack_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_fault_nxt = r_fault;
    case (r_state)
      IDLE: begin
        // A phase mismatch while nothing is outstanding means the far end toggled on its own.
        if (w_ack_s != r_req) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = FAULT;
        end else if (i_valid) begin
          w_data_nxt  = i_data;
          w_req_nxt   = ~r_req;
          w_cnt_nxt   = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_ack_s == r_req) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (TO_EN && (r_cnt == CNT_LAST)) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = FAULT;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      FAULT: begin
        // Realign our phase to whatever the far end currently shows.
        if (i_fault_clr) begin
          w_req_nxt   = w_ack_s;
          w_fault_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_req   = r_req;
  assign o_data  = r_data;
  assign o_done  = r_done;
  assign o_fault = r_fault;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a transaction-level reference model checked every cycle.
module tb_cdc_handshake_tx;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int TO    = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_ack_async = 1'b0;
  logic             i_fault_clr = 1'b0;
  logic             o_ready, o_req, o_done, o_fault;
  logic [WIDTH-1:0] o_data;

  int n_checks = 0;
  int n_errs   = 0;
  int n_done   = 0;

  always #5 i_clk = ~i_clk;

  cdc_handshake_tx #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_req       (o_req),
    .o_data      (o_data),
    .i_ack_async (i_ack_async),
    .o_done      (o_done),
    .o_fault     (o_fault),
    .i_fault_clr (i_fault_clr)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: ack is seen SYNC edges late; a transfer is outstanding from accept until
  // the delayed ack matches our phase, or until TO edges have passed without it.
  bit             m_req, m_done, m_flt, m_busy;
  logic [WIDTH-1:0] m_data;
  int             m_age;
  bit             m_ackq[$];

  always @(posedge i_clk or negedge i_rst_n) begin
    bit acks;
    if (!i_rst_n) begin
      m_req = 0; m_done = 0; m_flt = 0; m_busy = 0; m_data = '0; m_age = 0;
      m_ackq.delete();
      for (int i = 0; i < SYNC; i++) m_ackq.push_back(1'b0);
    end else begin
      acks = m_ackq.pop_front();
      m_ackq.push_back(i_ack_async);
      m_done = 0;
      if (m_flt) begin
        if (i_fault_clr) begin
          m_req = acks;
          m_flt = 0;
        end
      end else if (m_busy) begin
        if (acks == m_req) begin
          m_done = 1;
          m_busy = 0;
        end else begin
          m_age++;
          if (TO != 0 && m_age == TO) begin
            m_flt  = 1;
            m_busy = 0;
          end
        end
      end else if (acks != m_req) begin
        m_flt = 1;
      end else if (i_valid) begin
        m_data = i_data;
        m_req  = !m_req;
        m_busy = 1;
        m_age  = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    chk("cyc_req",   o_req,   m_req);
    chk("cyc_data",  o_data,  m_data);
    chk("cyc_done",  o_done,  m_done);
    chk("cyc_fault", o_fault, m_flt);
    chk("cyc_ready", o_ready, !m_busy && !m_flt);
    if (o_done === 1'b1) n_done++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (o_done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(name, o_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    i_rst_n = 1'b0;
    tick(3);
    chk("rst_req",   o_req,   0);
    chk("rst_data",  o_data,  0);
    chk("rst_ready", o_ready, 1);
    chk("rst_fault", o_fault, 0);
    chk("rst_done",  o_done,  0);
    i_rst_n = 1'b1;
    tick();

    // Single word, ack toggled three cycles after accept.
    i_valid = 1; i_data = 8'hA5;
    tick();
    i_valid = 0; i_data = 8'h00;
    chk("a5_req",   o_req,   1);
    chk("a5_data",  o_data,  8'hA5);
    chk("a5_ready", o_ready, 0);
    tick(2);
    i_ack_async = 1;
    tick(2);
    chk("a5_done_early", o_done, 0);
    chk("a5_data_hold",  o_data, 8'hA5);
    tick();
    chk("a5_done",  o_done,  1);
    chk("a5_ready_after", o_ready, 1);
    tick();
    chk("a5_done_pulse", o_done, 0);

    // Async reset in the middle of a transfer; far end reset alongside.
    i_valid = 1; i_data = 8'h3C;
    tick();
    i_valid = 0;
    tick(2);
    #2;
    i_rst_n = 0;
    i_ack_async = 0;
    #1;
    chk("arst_req",   o_req,   0);
    chk("arst_data",  o_data,  0);
    chk("arst_ready", o_ready, 1);
    chk("arst_fault", o_fault, 0);
    tick();
    i_rst_n = 1;
    tick();

    // Back-to-back words echoed by the far end.
    d0 = n_done;
    i_valid = 1; i_data = 8'h01;
    tick();
    i_valid = 0;
    chk("b1_req",  o_req,  1);
    chk("b1_data", o_data, 8'h01);
    tick();
    i_ack_async = 1;
    wait_done("b1_done");
    i_valid = 1; i_data = 8'h02;
    tick();
    i_valid = 0;
    chk("b2_req",  o_req,  0);
    chk("b2_data", o_data, 8'h02);
    tick();
    i_ack_async = 0;
    wait_done("b2_done");
    tick();
    chk("b2_done_count", n_done - d0, 2);
    chk("b2_fault", o_fault, 0);

    // Timeout with no ack, then recovery.
    i_valid = 1; i_data = 8'h77;
    tick();
    i_valid = 0;
    chk("to_ready", o_ready, 0);
    tick(15);
    chk("to_fault_early", o_fault, 0);
    tick();
    chk("to_fault", o_fault, 1);
    chk("to_ready_flt", o_ready, 0);
    chk("to_data_hold", o_data, 8'h77);
    chk("to_req_hold",  o_req,  1);
    i_fault_clr = 1;
    tick();
    chk("to_clr_fault", o_fault, 0);
    chk("to_clr_ready", o_ready, 1);
    chk("to_clr_req",   o_req,   0);
    tick();
    i_fault_clr = 0;
    chk("clr_idle_ignored", o_ready, 1);

    // Ack lands on the very cycle the timeout would fire.
    i_valid = 1; i_data = 8'h5A;
    tick();
    i_valid = 0;
    tick(13);
    i_ack_async = 1;
    tick(2);
    chk("race_done_early", o_done, 0);
    tick();
    chk("race_done",  o_done,  1);
    chk("race_fault", o_fault, 0);
    tick();
    chk("race_fault_after", o_fault, 0);
    chk("race_ready", o_ready, 1);

    // Spurious ack toggle while idle blocks accepts until cleared.
    tick(2);
    i_ack_async = 0;
    tick(2);
    i_valid = 1; i_data = 8'hEE;
    tick();
    chk("sp_fault", o_fault, 1);
    chk("sp_ready", o_ready, 0);
    chk("sp_data",  o_data,  8'h5A);
    tick(3);
    chk("sp_data_hold", o_data, 8'h5A);
    chk("sp_req_hold",  o_req,  1);
    i_fault_clr = 1;
    tick();
    i_fault_clr = 0;
    chk("sp_clr_fault", o_fault, 0);
    chk("sp_clr_req",   o_req,   0);
    chk("sp_clr_ready", o_ready, 1);
    tick();
    i_valid = 0;
    chk("sp_acc_req",  o_req,  1);
    chk("sp_acc_data", o_data, 8'hEE);
    i_ack_async = 1;
    wait_done("sp_done");
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
